life_engine: RTL and testbench

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/life_pkg.sv | 31 +++
 rtl/life_row_eval.sv | 37 +++
 rtl/life_engine.sv | 113 +++++++++++
 tb/tb_life_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared encodings and rule constants for the Game of Life engine.
package life_pkg;

   // Command encoding on the mode input.
   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_PROG  = 2'b01,
      MODE_RUN   = 2'b10,
      MODE_PAUSE = 2'b11
   } mode_e;

   // Controller states. S_PROG doubles as the hold state between generations.
   typedef enum logic [1:0] {
      S_IDLE,
      S_PROG,
      S_CALC,
      S_COMMIT
   } state_e;

   // Standard B3/S23 rule constants.
   localparam logic [3:0] SURVIVE_LO = 4'd2;
   localparam logic [3:0] SURVIVE_HI = 4'd3;
   localparam logic [3:0] BIRTH      = 4'd3;

   // Next state of one cell given its current state and live-neighbour count.
   function automatic logic next_cell(input logic alive, input logic [3:0] count);
      if (alive) return (count == SURVIVE_LO) || (count == SURVIVE_HI);
      return count == BIRTH;
   endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational evaluation of one grid row from the rows above and below it.
module life_row_eval
   import life_pkg::*;
#(
   parameter int COLS = 8,
   parameter int WRAP = 0
) (
   input  logic [COLS-1:0] above,
   input  logic [COLS-1:0] mid,
   input  logic [COLS-1:0] below,
   output logic [COLS-1:0] next_row
);

   logic [3:0] count;

   // Column lookup with horizontal edge handling: dead outside, or wrapped.
   function automatic logic pick(input logic [COLS-1:0] row, input int col);
      if (col < 0)     return (WRAP != 0) ? row[COLS-1] : 1'b0;
      if (col >= COLS) return (WRAP != 0) ? row[0] : 1'b0;
      return row[col];
   endfunction

   // Count the eight neighbours of every column in 4 bits and apply the rules.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      next_row = '0;
      count    = '0;
      for (int c = 0; c < COLS; c++) begin
         count = {3'b000, pick(above, c - 1)} + {3'b000, pick(above, c)} +
                 {3'b000, pick(above, c + 1)} + {3'b000, pick(mid, c - 1)} +
                 {3'b000, pick(mid, c + 1)}   + {3'b000, pick(below, c - 1)} +
                 {3'b000, pick(below, c)}     + {3'b000, pick(below, c + 1)};
         next_row[c] = next_cell(mid[c], count);
      end
   end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: serial programming, one row per cycle evaluation,
// single-cycle commit of a whole generation.
module life_engine
   import life_pkg::*;
#(
   parameter int COLS = 8,
   parameter int ROWS = 8,
   parameter int WRAP = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic                 pgm_valid,
   input  logic                 pgm_bit,
   input  logic                 step,
   output logic [ROWS*COLS-1:0] grid,
   output logic [15:0]          gen_count,
   output logic                 busy,
   output logic                 gen_done,
   output logic                 stable,
   output logic                 extinct
);

   localparam int CELLS = ROWS * COLS;
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(CELLS);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_CELL = CW'(CELLS - 1);

   state_e          state;
   logic [RW-1:0]   row_idx;
   logic [CW-1:0]   cell_idx;
   logic [CELLS-1:0] next_buf;
   logic [COLS-1:0] row_above;
   logic [COLS-1:0] row_mid;
   logic [COLS-1:0] row_below;
   logic [COLS-1:0] row_next;
   logic            start_gen;

   // A generation starts on RUN, or on a step request while paused.
   assign start_gen = (mode == MODE_RUN) || ((mode == MODE_PAUSE) && step);
   assign busy      = (state == S_CALC) || (state == S_COMMIT);
   assign extinct   = ~|grid;

   // Fetch the current row and its vertical neighbours from the frozen grid.
   always_comb begin
      row_above = '0;
      row_below = '0;
      row_mid   = grid[int'(row_idx)*COLS +: COLS];
      if (row_idx != '0)     row_above = grid[(int'(row_idx) - 1)*COLS +: COLS];
      else if (WRAP != 0)    row_above = grid[(ROWS - 1)*COLS +: COLS];
      if (row_idx != LAST_ROW) row_below = grid[(int'(row_idx) + 1)*COLS +: COLS];
      else if (WRAP != 0)    row_below = grid[0 +: COLS];
   end

   life_row_eval #(.COLS(COLS), .WRAP(WRAP)) u_row_eval (
      .above    (row_above),
      .mid      (row_mid),
      .below    (row_below),
      .next_row (row_next)
   );

   // Controller: programming, row-serial evaluation, commit and abort.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      gen_done <= 1'b0;
      if (rst || (mode == MODE_IDLE)) begin
         // NOTE: next_buf is cleared as well so an aborted generation leaves no stale rows.
         state     <= S_IDLE;
         grid      <= '0;
         next_buf  <= '0;
         gen_count <= '0;
         stable    <= 1'b0;
         cell_idx  <= '0;
         row_idx   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               row_idx <= '0;
               if (mode == MODE_PROG) state <= S_PROG;
               else if (start_gen)    state <= S_CALC;
            end
            S_PROG: begin
               if ((mode == MODE_PROG) && pgm_valid) begin
                  grid[cell_idx] <= pgm_bit;
                  cell_idx       <= (cell_idx == LAST_CELL) ? '0 : cell_idx + 1'b1;
               end
               if (start_gen) begin
                  state   <= S_CALC;
                  row_idx <= '0;
               end
            end
            S_CALC: begin
               next_buf[int'(row_idx)*COLS +: COLS] <= row_next;
               if (row_idx == LAST_ROW) begin
                  state   <= S_COMMIT;
                  row_idx <= '0;
               end else begin
                  row_idx <= row_idx + 1'b1;
               end
            end
            S_COMMIT: begin
               grid      <= next_buf;
               gen_done  <= 1'b1;
               gen_count <= (gen_count == 16'hFFFF) ? gen_count : gen_count + 16'd1;
               stable    <= (next_buf == grid);
               state     <= (mode == MODE_RUN) ? S_CALC : S_PROG;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: two instances (dead edges and toroidal)
// driven in lockstep and checked against a neighbourhood-counting model.
module tb_life_engine;
   import life_pkg::*;

   localparam int R = 8;
   localparam int C = 8;
   localparam int N = R * C;
   localparam logic [N-1:0] GLIDER = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                     (64'd1 << 17) | (64'd1 << 18);

   typedef struct {
      logic [N-1:0] grid;
      logic [15:0]  count;
      logic         stable;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        mode = MODE_IDLE;
   logic              pgm_valid = 1'b0;
   logic              pgm_bit = 1'b0;
   logic              step = 1'b0;
   logic [1:0][N-1:0] grid_o;
   logic [1:0][15:0]  count_o;
   logic [1:0]        busy_o, done_o, stable_o, extinct_o;

   int           tests = 0;
   int           fails = 0;
   exp_t         q0[$];
   exp_t         q1[$];
   logic [N-1:0] model_grid[2];
   logic [15:0]  model_count[2];
   bit           glider_watch = 0;
   bit           glider_hit = 0;

   life_engine #(.COLS(C), .ROWS(R), .WRAP(0)) dut_nowrap (
      .clk(clk), .rst(rst), .mode(mode), .pgm_valid(pgm_valid), .pgm_bit(pgm_bit),
      .step(step), .grid(grid_o[0]), .gen_count(count_o[0]), .busy(busy_o[0]),
      .gen_done(done_o[0]), .stable(stable_o[0]), .extinct(extinct_o[0]));

   life_engine #(.COLS(C), .ROWS(R), .WRAP(1)) dut_wrap (
      .clk(clk), .rst(rst), .mode(mode), .pgm_valid(pgm_valid), .pgm_bit(pgm_bit),
      .step(step), .grid(grid_o[1]), .gen_count(count_o[1]), .busy(busy_o[1]),
      .gen_done(done_o[1]), .stable(stable_o[1]), .extinct(extinct_o[1]));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int w, input logic [N-1:0] act,
                        input logic [N-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (dut %0d): actual %h expected %h", name, w, act, exp);
      end
   endtask

   // Reference: count the eight neighbours of every cell directly.
   function automatic logic [N-1:0] model_next(input logic [N-1:0] g, input bit wrap);
      logic [N-1:0] n;
      n = '0;
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            int live;
            live = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr, cc;
                  rr = r + dr;
                  cc = c + dc;
                  if (wrap) begin
                     rr = (rr + R) % R;
                     cc = (cc + C) % C;
                  end
                  if ((dr != 0 || dc != 0) && rr >= 0 && rr < R && cc >= 0 && cc < C &&
                      g[rr*C + cc])
                     live++;
               end
            end
            n[r*C + c] = (live == 3) || (g[r*C + c] && live == 2);
         end
      end
      return n;
   endfunction

   task automatic model_clear();
      for (int w = 0; w < 2; w++) begin
         model_grid[w]  = '0;
         model_count[w] = '0;
      end
   endtask

   // Predict one generation for both edge modes and queue the expectations.
   task automatic push_gen();
      for (int w = 0; w < 2; w++) begin
         exp_t e;
         logic [N-1:0] nx;
         nx       = model_next(model_grid[w], w == 1);
         e.grid   = nx;
         e.count  = (model_count[w] == 16'hFFFF) ? model_count[w] : model_count[w] + 16'd1;
         e.stable = (nx == model_grid[w]);
         model_grid[w]  = nx;
         model_count[w] = e.count;
         if (w == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   // Monitor: every gen_done pops one expectation per instance and compares.
   always @(negedge clk) begin
      exp_t e;
      int   sz;
      for (int w = 0; w < 2; w++) begin
         if (done_o[w]) begin
            sz = (w == 0) ? q0.size() : q1.size();
            check("sb_has_entry", w, N'(sz != 0), N'(1));
            if (sz != 0) begin
               if (w == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               check("sb_grid", w, grid_o[w], e.grid);
               check("sb_gen_count", w, N'(count_o[w]), N'(e.count));
               check("sb_stable", w, N'(stable_o[w]), N'(e.stable));
               check("sb_extinct", w, N'(extinct_o[w]), N'(e.grid == '0));
            end
         end
      end
      if (glider_watch && done_o[0] && grid_o[0] == GLIDER) glider_hit = 1;
   end

   // Clear through IDLE, then serially program all cells from index 0.
   task automatic load_grid(input logic [N-1:0] g);
      @(negedge clk);
      mode = MODE_IDLE;
      step = 1'b0;
      @(negedge clk);
      mode = MODE_PROG;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         pgm_valid = 1'b1;
         pgm_bit   = g[i];
         @(negedge clk);
      end
      pgm_valid = 1'b0;
      model_clear();
      model_grid[0] = g;
      model_grid[1] = g;
      check("load_grid", 0, grid_o[0], g);
      check("load_grid", 1, grid_o[1], g);
   endtask

   // Run n generations in RUN, dropping to PAUSE during the last one.
   task automatic run_gens(input int n);
      int seen, busy_cycles, last, budget;
      seen = 0; busy_cycles = 0; last = 0; budget = 0;
      mode = MODE_RUN;
      push_gen();
      while (seen < n && budget < n*(R+1) + 20) begin
         @(negedge clk);
         budget++;
         if (n == 1 && budget == 1) mode = MODE_PAUSE;
         if (done_o[0]) begin
            seen++;
            if (seen == 1) check("busy_cycles_first_gen", 0, N'(busy_cycles), N'(R + 1));
            else           check("gen_period", 0, N'(budget - last), N'(R + 1));
            last = budget;
            if (seen < n) push_gen();
            if (seen == n - 1) mode = MODE_PAUSE;
         end else if (busy_o[0] && seen == 0) begin
            busy_cycles++;
         end
      end
      check("run_gens_completed", 0, N'(seen), N'(n));
   endtask

   // One step in PAUSE with step held for 'hold' cycles; only one generation allowed.
   task automatic step_once(input int hold);
      int seen;
      seen = 0;
      mode = MODE_PAUSE;
      step = 1'b1;
      push_gen();
      repeat (hold) @(negedge clk);
      step = 1'b0;
      for (int i = 0; i < R + 8; i++) begin
         if (done_o[0]) seen++;
         @(negedge clk);
      end
      check("step_single_gen", 0, N'(seen), N'(1));
   endtask

   initial begin
      logic [N-1:0] g;
      int dones;
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         check("reset_grid", w, grid_o[w], '0);
         check("reset_gen_count", w, N'(count_o[w]), '0);
         check("reset_busy", w, N'(busy_o[w]), '0);
         check("reset_gen_done", w, N'(done_o[w]), '0);
         check("reset_stable", w, N'(stable_o[w]), '0);
         check("reset_extinct", w, N'(extinct_o[w]), N'(1));
      end

      // Step is ignored in IDLE.
      step = 1'b1;
      repeat (3) @(negedge clk);
      step = 1'b0;
      check("idle_step_ignored", 0, N'(busy_o[0]), '0);

      // Blinker.
      load_grid((64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
      run_gens(1);
      check("blinker_grid", 0, grid_o[0], (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35));
      check("blinker_gen_count", 0, N'(count_o[0]), N'(1));

      // Block still-life with step held for several cycles.
      load_grid((64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36));
      step_once(3);
      check("block_grid", 0, grid_o[0], (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36));
      check("block_stable", 0, N'(stable_o[0]), N'(1));
      check("block_gen_count", 0, N'(count_o[0]), N'(1));

      // Glider in both edge modes.
      load_grid(GLIDER);
      glider_hit   = 0;
      glider_watch = 1;
      run_gens(32);
      glider_watch = 0;
      check("glider_wrap_returns", 1, grid_o[1], GLIDER);
      check("glider_nowrap_never_start", 0, N'(glider_hit), '0);
      check("glider_gen_count", 1, N'(count_o[1]), N'(32));

      // Randomised patterns, mixing RUN bursts and PAUSE steps.
      for (int k = 0; k < 6; k++) begin
         g = {$urandom, $urandom};
         load_grid(g);
         if ($urandom_range(0, 1) == 0) run_gens(int'($urandom_range(1, 4)));
         else                           step_once(1);
      end

      // Program index wraps from the last cell back to 0.
      @(negedge clk);
      mode = MODE_IDLE;
      @(negedge clk);
      mode = MODE_PROG;
      @(negedge clk);
      for (int i = 0; i <= N; i++) begin
         pgm_valid = 1'b1;
         pgm_bit   = (i < N);
         @(negedge clk);
      end
      pgm_valid = 1'b0;
      check("program_wrap", 0, grid_o[0], 64'hFFFF_FFFF_FFFF_FFFE);
      check("program_wrap", 1, grid_o[1], 64'hFFFF_FFFF_FFFF_FFFE);

      // Reset in the third S_CALC cycle, with RUN still applied.
      load_grid(GLIDER);
      run_gens(1);
      mode = MODE_RUN;
      repeat (3) @(negedge clk);
      check("busy_before_reset", 0, N'(busy_o[0]), N'(1));
      rst = 1'b1;
      @(negedge clk);
      check("midcalc_reset_grid", 0, grid_o[0], '0);
      check("midcalc_reset_gen_count", 0, N'(count_o[0]), '0);
      check("midcalc_reset_busy", 0, N'(busy_o[0]), '0);
      check("midcalc_reset_gen_done", 0, N'(done_o[0]), '0);
      mode = MODE_IDLE;
      rst  = 1'b0;
      model_clear();

      // Abort with mode 00 in the middle of S_CALC.
      load_grid((64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
      run_gens(1);
      mode = MODE_RUN;
      repeat (4) @(negedge clk);
      mode  = MODE_IDLE;
      dones = 0;
      for (int i = 0; i < R + 4; i++) begin
         @(negedge clk);
         if (done_o[0]) dones++;
      end
      model_clear();
      check("abort_no_gen_done", 0, N'(dones), '0);
      check("abort_gen_count", 0, N'(count_o[0]), '0);
      check("abort_grid", 0, grid_o[0], '0);
      check("abort_busy", 0, N'(busy_o[0]), '0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 0, N'(q0.size()), '0);
      check("scoreboard_drained", 1, N'(q1.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
